axil_cache_frontend: RTL
========================

Name: axil_cache_frontend

Overview:
- AXI4-Lite slave front-end of the cache wrapper. It sits directly downstream of the AXI master (VIP in simulation, PS/interconnect in hardware) and directly upstream of the cache core.
- Converts AXI4-Lite reads and writes into single-word cache requests, one at a time, and returns responses on the B and R channels.
- Buffers AW and W independently, arbitrates read against write fairly, and rejects out-of-range addresses with SLVERR without touching the cache.

Parameters:
ADDR_WIDTH, 32, AXI and cache byte-address width
DATA_WIDTH, 32, data width; only 32 supported (STRB_WIDTH = DATA_WIDTH/8)
ADDR_LIMIT, 32'h0001_0000, first illegal byte address; addr >= ADDR_LIMIT gets SLVERR

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel (AWPROT ignored)
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel (ARPROT ignored)
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
cache_req_valid  out  1  request to cache core
cache_req_ready  in  1  cache accepts request
cache_req_we  out  1  1 = write, 0 = read
cache_req_addr  out  ADDR_WIDTH  word-aligned byte address, bits [1:0] forced to 0
cache_req_wdata  out  32  write data
cache_req_wstrb  out  4  byte enables
cache_rsp_valid  in  1  one-cycle pulse: request complete (reads and writes)
cache_rsp_rdata  in  32  read data, valid while cache_rsp_valid is high

Behaviour:
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, cache_req_* 0, state IDLE, both buffers empty, priority bit = write-first. Reset is asynchronous and may assert at any state; every in-flight transaction is dropped. The cache core shares ARESET.
- AW buffer: AWREADY = !aw_full. On AWVALID&&AWREADY, latch address and set aw_full.
- W buffer: WREADY = !w_full. On WVALID&&WREADY, latch data/strobe and set w_full. AW and W may arrive in either order or in the same cycle.
- AR buffer: ARREADY = !ar_full. Latch on handshake.
- Buffers clear when their transaction is issued to the cache or when SLVERR is decided. No new AW/W/AR handshake is taken while the corresponding buffer is full.
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE: write is eligible when aw_full && w_full; read is eligible when ar_full.
  - If both are eligible, the priority bit decides; the bit toggles after each granted transaction. After reset, write wins.
  - If address >= ADDR_LIMIT, go straight to WR_RESP/RD_RESP with resp 2'b10. RDATA is 0 for a rejected read.
  - Otherwise go to WR_REQ/RD_REQ with resp 2'b00.
- WR_REQ/RD_REQ: cache_req_valid=1 with stable we/addr/wdata/wstrb until cache_req_ready. The cycle cache_req_ready is seen, go to *_WAIT; cache_req_valid drops the next cycle. For reads, cache_req_wstrb=0.
- WR_WAIT/RD_WAIT: wait for cache_rsp_valid. In RD_WAIT, capture cache_rsp_rdata into the RDATA register. Next state is *_RESP.
- WR_RESP: BVALID=1 until BREADY; then IDLE. RD_RESP: RVALID=1 with RDATA/RRESP stable until RREADY; then IDLE.
- Latency: cache_rsp_valid at cycle N gives BVALID/RVALID at N+1. Best-case AXI-to-cache-request is 2 cycles (buffer latch, then IDLE decision).
- Next-transaction buffering: during a write's processing the AR buffer may still fill, and vice versa. The buffers themselves act as one-deep skid.
- A cache_rsp_valid outside a *_WAIT state is ignored (protocol error; assertion in sim).
- One outstanding cache request at any time; no speculative issue.

Decomposition:
- Package axil_cache_pkg: AXI resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, FSM state enum, and a struct cache_req_t {we, addr, wdata, wstrb} shared with the cache core.
- Sub-module axil_skid_reg (valid/ready one-entry holding register, parameterised width) is instantiated three times for AW, W and AR.
- FSM and arbiter stay in the top module.

Test Plan:
- Sequential writes of 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with a model cache (ready=1, rsp 2 cycles later), then read back -> four BRESP=OKAY, RDATA 0x1..0x4 in order, four cache writes with wstrb=4'hF and addr bits[1:0]=0.
- W presented 3 cycles before AW (data 0xDEADBEEF at 0x10), then AW/W in the same cycle -> single cache write per transaction with the correct pairing; WREADY low while w_full.
- ARVALID and AW+W valid in the same cycle, twice in a row -> first grant is write, then read, then write, then read (round-robin); no starvation.
- Read at 0x0001_0000 and write at 0xFFFF_FFFC -> RRESP=BRESP=2'b10, RDATA=0, cache_req_valid never asserts.
- Cache holds cache_req_ready low 5 cycles; BREADY/RREADY held low 4 cycles -> request fields stable throughout; BVALID/RVALID and data stable until the handshake.
- ARESET asserted in RD_WAIT -> all outputs 0 asynchronously. After release, a fresh write/read to 0x8 completes OKAY with correct data.

Source files
------------

// File: rtl/axil_cache_pkg.sv
// Types and constants shared between the AXI4-Lite front-end and the cache core.
package axil_cache_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int REQ_AW = 32;
   localparam int REQ_DW = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [REQ_AW-1:0]     addr;
      logic [REQ_DW-1:0]     wdata;
      logic [REQ_DW/8-1:0]   wstrb;
   } cache_req_t;

endpackage

// File: rtl/axil_skid_reg.sv
// One-entry valid/ready holding register: the entry is visible the cycle after the handshake and
// ready stays low while it is occupied (and for the first cycle after reset).
module axil_skid_reg #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_vld,
   output logic             o_rdy,
   input  logic [WIDTH-1:0] i_dat,
   output logic             o_full,
   output logic [WIDTH-1:0] o_dat,
   input  logic             i_clr
);

   logic             r_en;
   logic             r_full;
   logic [WIDTH-1:0] r_dat;

   assign o_rdy  = r_en && !r_full;
   assign o_full = r_full;
   assign o_dat  = r_dat;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_en   <= 1'b0;
         r_full <= 1'b0;
         r_dat  <= '0;
      end else begin
         r_en <= 1'b1;
         // A fill and a clear never coincide: fill needs empty, clear needs full.
         if (i_vld && o_rdy) begin
            r_full <= 1'b1;
            r_dat  <= i_dat;
         end else if (i_clr) begin
            r_full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/axil_cache_frontend.sv
// AXI4-Lite slave that turns each read/write into one cache request; >=2 cycles AXI-to-request,
// B/R one cycle after the cache response; AW/W/AR each hold one entry and stall their channel while full.
module axil_cache_frontend
   import axil_cache_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 32'h0001_0000
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                S_AXI_AWPROT,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [1:0]                S_AXI_BRESP,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                S_AXI_ARPROT,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY,
   output logic                      cache_req_valid,
   input  logic                      cache_req_ready,
   output logic                      cache_req_we,
   output logic [ADDR_WIDTH-1:0]     cache_req_addr,
   output logic [DATA_WIDTH-1:0]     cache_req_wdata,
   output logic [DATA_WIDTH/8-1:0]   cache_req_wstrb,
   input  logic                      cache_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     cache_rsp_rdata
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                             w_aw_full;
   logic                             w_w_full;
   logic                             w_ar_full;
   logic [ADDR_WIDTH-1:0]            w_aw_addr;
   logic [ADDR_WIDTH-1:0]            w_ar_addr;
   logic [STRB_WIDTH+DATA_WIDTH-1:0] w_w_dat;
   logic [DATA_WIDTH-1:0]            w_w_data;
   logic [STRB_WIDTH-1:0]            w_w_strb;
   logic                             w_aw_clr;
   logic                             w_w_clr;
   logic                             w_ar_clr;
   logic                             w_wr_elig;
   logic                             w_rd_elig;
   logic                             w_grant_wr;
   logic                             w_unused_prot;

   state_t                r_state;
   state_t                w_state_nxt;
   cache_req_t            r_req;
   cache_req_t            w_req_nxt;
   logic                  r_prio_wr;
   logic                  w_prio_wr_nxt;
   logic [1:0]            r_bresp;
   logic [1:0]            w_bresp_nxt;
   logic [1:0]            r_rresp;
   logic [1:0]            w_rresp_nxt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] w_rdata_nxt;

   assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
      .i_clk  (ACLK),
      .i_rst  (ARESET),
      .i_vld  (S_AXI_AWVALID),
      .o_rdy  (S_AXI_AWREADY),
      .i_dat  (S_AXI_AWADDR),
      .o_full (w_aw_full),
      .o_dat  (w_aw_addr),
      .i_clr  (w_aw_clr)
   );

   axil_skid_reg #(.WIDTH(STRB_WIDTH + DATA_WIDTH)) u_w_buf (
      .i_clk  (ACLK),
      .i_rst  (ARESET),
      .i_vld  (S_AXI_WVALID),
      .o_rdy  (S_AXI_WREADY),
      .i_dat  ({S_AXI_WSTRB, S_AXI_WDATA}),
      .o_full (w_w_full),
      .o_dat  (w_w_dat),
      .i_clr  (w_w_clr)
   );

   axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
      .i_clk  (ACLK),
      .i_rst  (ARESET),
      .i_vld  (S_AXI_ARVALID),
      .o_rdy  (S_AXI_ARREADY),
      .i_dat  (S_AXI_ARADDR),
      .o_full (w_ar_full),
      .o_dat  (w_ar_addr),
      .i_clr  (w_ar_clr)
   );

   assign w_w_data   = w_w_dat[DATA_WIDTH-1:0];
   assign w_w_strb   = w_w_dat[STRB_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
   assign w_wr_elig  = w_aw_full && w_w_full;
   assign w_rd_elig  = w_ar_full;
   assign w_grant_wr = w_wr_elig && (r_prio_wr || !w_rd_elig);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state   <= ST_IDLE;
         r_req     <= '0;
         r_prio_wr <= 1'b1;
         r_bresp   <= RESP_OKAY;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_req     <= w_req_nxt;
         r_prio_wr <= w_prio_wr_nxt;
         r_bresp   <= w_bresp_nxt;
         r_rresp   <= w_rresp_nxt;
         r_rdata   <= w_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_req_nxt       = r_req;
      w_prio_wr_nxt   = r_prio_wr;
      w_bresp_nxt     = r_bresp;
      w_rresp_nxt     = r_rresp;
      w_rdata_nxt     = r_rdata;
      w_aw_clr        = 1'b0;
      w_w_clr         = 1'b0;
      w_ar_clr        = 1'b0;
      cache_req_valid = 1'b0;
      S_AXI_BVALID    = 1'b0;
      S_AXI_RVALID    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_wr) begin
               w_aw_clr      = 1'b1;
               w_w_clr       = 1'b1;
               w_prio_wr_nxt = !r_prio_wr;
               if (w_aw_addr >= ADDR_LIMIT) begin
                  w_bresp_nxt = RESP_SLVERR;
                  w_state_nxt = ST_WR_RESP;
               end else begin
                  w_bresp_nxt     = RESP_OKAY;
                  w_req_nxt.we    = 1'b1;
                  w_req_nxt.addr  = REQ_AW'({w_aw_addr[ADDR_WIDTH-1:2], 2'b00});
                  w_req_nxt.wdata = REQ_DW'(w_w_data);
                  w_req_nxt.wstrb = (REQ_DW/8)'(w_w_strb);
                  w_state_nxt     = ST_WR_REQ;
               end
            end else if (w_rd_elig) begin
               w_ar_clr      = 1'b1;
               w_prio_wr_nxt = !r_prio_wr;
               w_rdata_nxt   = '0;
               if (w_ar_addr >= ADDR_LIMIT) begin
                  w_rresp_nxt = RESP_SLVERR;
                  w_state_nxt = ST_RD_RESP;
               end else begin
                  w_rresp_nxt     = RESP_OKAY;
                  w_req_nxt.we    = 1'b0;
                  w_req_nxt.addr  = REQ_AW'({w_ar_addr[ADDR_WIDTH-1:2], 2'b00});
                  w_req_nxt.wdata = '0;
                  w_req_nxt.wstrb = '0;
                  w_state_nxt     = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            cache_req_valid = 1'b1;
            if (cache_req_ready) w_state_nxt = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (cache_rsp_valid) w_state_nxt = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) w_state_nxt = ST_IDLE;
         end
         ST_RD_REQ: begin
            cache_req_valid = 1'b1;
            if (cache_req_ready) w_state_nxt = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (cache_rsp_valid) begin
               w_rdata_nxt = cache_rsp_rdata;
               w_state_nxt = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign cache_req_we    = r_req.we;
   assign cache_req_addr  = r_req.addr[ADDR_WIDTH-1:0];
   assign cache_req_wdata = r_req.wdata[DATA_WIDTH-1:0];
   assign cache_req_wstrb = r_req.wstrb[STRB_WIDTH-1:0];
   assign S_AXI_BRESP     = r_bresp;
   assign S_AXI_RRESP     = r_rresp;
   assign S_AXI_RDATA     = r_rdata;

   // The cache only ever answers an issued request; anything else is dropped by the FSM.
   a_rsp_only_in_wait : assert property (@(posedge ACLK) disable iff (ARESET)
      cache_rsp_valid |-> (r_state == ST_WR_WAIT || r_state == ST_RD_WAIT));

endmodule
